// File: rtl/ssg_emb_sd_adc_dec_ctrl.sv
// Sinc3 decimator sequencer: decimation strobe, frame-aligned rate changes, settle discard, output qualify.
// Optional zero-offset calibration is built when SSG_EMB_SD_ADC_OFFSET_CAL_EN is defined.
module ssg_emb_sd_adc_dec_ctrl #(
  parameter int SETTLE_CNT = 3,
  parameter int LATENCY    = 3,
  parameter int CAL_SHIFT  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        dec_rate_req,
  input  logic [15:0] offset_cfg,
  input  logic        cal_start,
  input  logic [15:0] sample_in,
  output logic        cnr64,
  output logic        dec_rate,
  output logic [15:0] offset_out,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        settled,
  output logic        cal_done
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, CAL} state_t;

  state_t            state, state_next;
  logic [5:0]        count, count_next;
  logic [5:0]        last, last_next;
  logic [2:0]        settle_cnt, settle_cnt_next;
  logic              dec_rate_next;
  logic              rate_change;
  logic              cal_go;
  logic              cal_finish;
  logic [LATENCY-2:0] pipe_run;
  logic              capture_run;

  // A rate request is only honoured on a frame boundary (strobe cycle).
  assign rate_change = cnr64 && (dec_rate_req != dec_rate);
  assign capture_run = pipe_run[LATENCY-2] && (state == RUN) && enable;
  assign settled     = (state == RUN) || (state == CAL);
  assign last        = dec_rate ? 6'd31 : 6'd63;
  assign last_next   = dec_rate_next ? 6'd31 : 6'd63;

  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    dec_rate_next   = dec_rate;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_next      = SETTLE;
          settle_cnt_next = 3'd0;
          dec_rate_next   = dec_rate_req;
        end
        default: begin
          if (rate_change) begin
            state_next      = SETTLE;
            settle_cnt_next = 3'd0;
            dec_rate_next   = dec_rate_req;
          end else if ((state == SETTLE) && cnr64) begin
            if (settle_cnt == 3'(SETTLE_CNT - 1)) state_next = RUN;
            else settle_cnt_next = settle_cnt + 3'd1;
          end else if (cal_go) begin
            state_next = CAL;
          end else if (cal_finish) begin
            state_next = RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    count_next = count + 6'd1;
    if ((state_next == IDLE) || (state == IDLE) || (count == last)) count_next = 6'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= 6'd0;
      settle_cnt   <= 3'd0;
      dec_rate     <= 1'b0;
      cnr64        <= 1'b0;
      pipe_run     <= '0;
      sample_out   <= 16'd0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      settle_cnt   <= settle_cnt_next;
      dec_rate     <= dec_rate_next;
      cnr64        <= (state_next != IDLE) && (count_next == last_next);
      sample_valid <= capture_run;
      if (capture_run) sample_out <= sample_in;
      // Each pipe bit tags a strobe issued while running; dropping enable flushes it.
      if (state_next == IDLE) begin
        pipe_run <= '0;
      end else begin
        pipe_run[0] <= cnr64 && (state == RUN);
        for (int i = 1; i < LATENCY - 1; i++) pipe_run[i] <= pipe_run[i-1];
      end
    end
  end

`ifdef SSG_EMB_SD_ADC_OFFSET_CAL_EN
  localparam int AW = 16 + CAL_SHIFT;

  logic [LATENCY-2:0]   pipe_cal;
  logic signed [AW-1:0] acc, acc_sum;
  logic [CAL_SHIFT-1:0] cal_cnt;
  logic                 cal_take;
  logic [17:0]          ofs_sum;
  logic [15:0]          ofs_clamped;

  assign cal_go     = (state == RUN) && cal_start;
  assign cal_take   = pipe_cal[LATENCY-2] && (state == CAL) && enable;
  assign cal_finish = cal_take && (&cal_cnt);
  assign acc_sum    = acc + {{CAL_SHIFT{sample_in[15]}}, sample_in};
  // Average halved: the upper slice is (acc >>> CAL_SHIFT) >>> 1, sign-extended to 18 bits.
  assign ofs_sum    = {2'b00, offset_out} + {{3{acc_sum[AW-1]}}, acc_sum[AW-1:CAL_SHIFT+1]};
  assign ofs_clamped = ofs_sum[17] ? 16'h0000 : (ofs_sum[16] ? 16'hFFFF : ofs_sum[15:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_cal   <= '0;
      acc        <= '0;
      cal_cnt    <= '0;
      offset_out <= 16'd0;
      cal_done   <= 1'b0;
    end else begin
      cal_done <= cal_finish;
      if (state_next == IDLE) begin
        pipe_cal <= '0;
      end else begin
        pipe_cal[0] <= cnr64 && (state == CAL);
        for (int i = 1; i < LATENCY - 1; i++) pipe_cal[i] <= pipe_cal[i-1];
      end
      if ((state == IDLE) && enable) offset_out <= offset_cfg;
      else if (cal_finish)           offset_out <= ofs_clamped;
      if ((state == RUN) && (state_next == CAL)) begin
        acc     <= '0;
        cal_cnt <= '0;
      end else if (cal_take) begin
        acc     <= acc_sum;
        cal_cnt <= cal_cnt + CAL_SHIFT'(1);
      end
    end
  end
`else
  logic cal_start_unused;

  assign cal_start_unused = cal_start;
  assign cal_go           = 1'b0;
  assign cal_finish       = 1'b0;
  assign cal_done         = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) offset_out <= 16'd0;
    else          offset_out <= offset_cfg;
  end
`endif

endmodule

// File: tb/tb_ssg_emb_sd_adc_dec_ctrl.sv
// Directed bench for ssg_emb_sd_adc_dec_ctrl; expected captures are queued and checked by a monitor.
module tb_ssg_emb_sd_adc_dec_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        dec_rate_req = 1'b0;
  logic [15:0] offset_cfg = 16'h0100;
  logic        cal_start = 1'b0;
  logic [15:0] sample_in;
  logic        cnr64, dec_rate, sample_valid, settled, cal_done;
  logic [15:0] offset_out, sample_out;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        ramp_en = 1'b1;
  logic [15:0] const_val = 16'h0000;
  int          exp_cyc[$];
  logic [15:0] exp_val[$];

  ssg_emb_sd_adc_dec_ctrl dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dec_rate_req(dec_rate_req),
    .offset_cfg(offset_cfg), .cal_start(cal_start), .sample_in(sample_in),
    .cnr64(cnr64), .dec_rate(dec_rate), .offset_out(offset_out), .sample_out(sample_out),
    .sample_valid(sample_valid), .settled(settled), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  // sample_in changes just after each rising edge; the DUT registers the previous cycle's value.
  initial begin
    sample_in = 16'h0000;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      sample_in = ramp_en ? 16'(cyc) : const_val;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
    check("schedule", cyc, n);
  endtask

  // A strobe at cycle p yields a valid at p+3 carrying what sample_in held at that edge.
  task automatic push(input int pulse, input logic [15:0] val);
    exp_cyc.push_back(pulse + 3);
    exp_val.push_back(val);
  endtask

  initial begin : monitor
    int          ec;
    logic [15:0] ev;
    forever begin
      @(negedge clk);
      if (sample_valid === 1'b1) begin
        $display("valid cycle=%0d sample_out=%h", cyc, sample_out);
        if (exp_cyc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: actual valid at cycle %0d, required none", cyc);
        end else begin
          ec = exp_cyc.pop_front();
          ev = exp_val.pop_front();
          check("valid_cycle", cyc, ec);
          check("sample_out", {16'd0, sample_out}, {16'd0, ev});
        end
      end
    end
  end

  initial begin : stim
    int e0, e1, base, pulses, setl;
    e0 = 10;

    goto(2);
    check("rst_cnr64", cnr64, 0);
    check("rst_dec_rate", dec_rate, 0);
    check("rst_offset", offset_out, 0);
    check("rst_sample_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_settled", settled, 0);
    check("rst_cal_done", cal_done, 0);
    goto(3);
    reset_n = 1'b1;
    goto(5);
`ifdef SSG_EMB_SD_ADC_OFFSET_CAL_EN
    check("idle_offset", offset_out, 16'h0000);
`else
    check("idle_offset", offset_out, 16'h0100);
`endif
    check("idle_settled", settled, 0);
    check("idle_cnr64", cnr64, 0);

    // Start at M=64: strobes at e0+64k, first three discarded.
    goto(e0);
    enable = 1'b1;
    dec_rate_req = 1'b0;
    push(e0 + 256, 16'(e0 + 258));
    push(e0 + 320, 16'(e0 + 322));
    goto(e0 + 1);
    check("start_offset", offset_out, 16'h0100);
    check("start_dec_rate", dec_rate, 0);
    goto(e0 + 63);  check("first_cnr_pre", cnr64, 0);
    goto(e0 + 64);  check("first_cnr", cnr64, 1);
    goto(e0 + 65);  check("first_cnr_post", cnr64, 0);
    goto(e0 + 192); check("settle_lo", settled, 0);
    goto(e0 + 193); check("settle_hi", settled, 1);

    // Rate request raised mid-frame (count=10) takes effect after the next strobe.
    goto(e0 + 331);
    dec_rate_req = 1'b1;
    goto(e0 + 384); check("rc_cnr", cnr64, 1); check("rc_rate_old", dec_rate, 0);
    goto(e0 + 385); check("rc_rate_new", dec_rate, 1); check("rc_settled", settled, 0);
    goto(e0 + 415); check("m32_cnr_pre", cnr64, 0);
    goto(e0 + 416); check("m32_cnr", cnr64, 1);
    goto(e0 + 480); check("rc_settle_lo", settled, 0);
    goto(e0 + 481); check("rc_settle_hi", settled, 1);
    push(e0 + 512, 16'(e0 + 514));

`ifdef SSG_EMB_SD_ADC_OFFSET_CAL_EN
    goto(e0 + 516);
    ramp_en = 1'b0;
    const_val = 16'h0040;
    goto(e0 + 520); cal_start = 1'b1;
    goto(e0 + 521); cal_start = 1'b0;
    check("cal_settled", settled, 1);
    goto(e0 + 600); check("cal_mid_settled", settled, 1);
    goto(e0 + 1026); check("cal1_done_pre", cal_done, 0); check("cal1_ofs_pre", offset_out, 16'h0100);
    goto(e0 + 1027); check("cal1_done", cal_done, 1); check("cal1_ofs", offset_out, 16'h0120);
    goto(e0 + 1028); check("cal1_done_post", cal_done, 0);
    push(e0 + 1056, 16'h0040);
    goto(e0 + 1060); const_val = 16'h8001;
    goto(e0 + 1062); cal_start = 1'b1;
    goto(e0 + 1063); cal_start = 1'b0;
    goto(e0 + 1570); check("cal2_done_pre", cal_done, 0);
    goto(e0 + 1571); check("cal2_done", cal_done, 1); check("cal2_clamp", offset_out, 16'h0000);
    push(e0 + 1600, 16'h8001);
    base = e0 + 1600;
`else
    push(e0 + 544, 16'(e0 + 546));
    push(e0 + 576, 16'(e0 + 578));
    goto(e0 + 520); cal_start = 1'b1;
    goto(e0 + 521); cal_start = 1'b0;
    check("nocal_settled", settled, 1);
    check("nocal_done", cal_done, 0);
    goto(e0 + 530);
    offset_cfg = 16'hBEEF;
    check("ofs_hold", offset_out, 16'h0100);
    goto(e0 + 531); check("ofs_follow", offset_out, 16'hBEEF);
    base = e0 + 576;
`endif

    // Disable at count=20 in RUN.
    goto(base + 21);
    check("pre_dis_settled", settled, 1);
    enable = 1'b0;
    goto(base + 22); check("dis_cnr", cnr64, 0); check("dis_settled", settled, 0);
    ramp_en = 1'b1;
    dec_rate_req = 1'b0;

    // Re-enable at M=64 and settle again.
    e1 = base + 40;
    goto(e1);
    enable = 1'b1;
    push(e1 + 256, 16'(e1 + 258));
    goto(e1 + 1);   check("re_rate", dec_rate, 0); check("re_settled", settled, 0);
    goto(e1 + 63);  check("re_cnr_pre", cnr64, 0);
    goto(e1 + 64);  check("re_cnr", cnr64, 1);
    goto(e1 + 192); check("re_settle_lo", settled, 0);
    goto(e1 + 193); check("re_settle_hi", settled, 1);

    // Reset two cycles after a strobe kills the in-flight capture.
    goto(e1 + 322);
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("ar_cnr64", cnr64, 0);
    check("ar_dec_rate", dec_rate, 0);
    check("ar_offset", offset_out, 0);
    check("ar_sample_out", sample_out, 0);
    check("ar_valid", sample_valid, 0);
    check("ar_settled", settled, 0);
    check("ar_cal_done", cal_done, 0);
    goto(e1 + 324);
    reset_n = 1'b1;
    pulses = 0;
    setl = 0;
    for (int c = e1 + 325; c <= e1 + 400; c++) begin
      goto(c);
      pulses += int'(cnr64);
      setl += int'(settled);
    end
    check("post_rst_cnr_count", pulses, 0);
    check("post_rst_settled_count", setl, 0);
`ifdef SSG_EMB_SD_ADC_OFFSET_CAL_EN
    check("post_rst_offset", offset_out, 16'h0000);
`else
    check("post_rst_offset", offset_out, 16'hBEEF);
`endif
    goto(e1 + 410);
    check("pending_valids", exp_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
